fifo_uart_tx: RTL and testbench

//  Read-side consumer for fifo_sync_8bit: drains bytes from the FIFO read port and serialises

---
 rtl/fifo_uart_tx.sv | 162 ++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// Drains bytes from a synchronous FIFO read port and sends each one as an
// 8N1 or 8N2 UART frame. Each frame fetches exactly one byte from the FIFO.
//
// Parameters
//   pClkDiv    clock cycles per UART bit (>= 2)
//   pStopBits  stop bits per frame (1 or 2)
// Ports
//   iClk        system clock, rising edge
//   iRst        synchronous active-high reset
//   iEn         allows new bytes to be fetched from the FIFO
//   iFifoEmpty  FIFO empty flag
//   iFifoData   FIFO read data, valid the cycle after oFifoRdEn
//   oFifoRdEn   single-cycle FIFO read strobe, one per frame
//   oTx         UART line, idles high
//   oBusy       high from the fetch cycle through the last stop-bit cycle
//   oByteDone   one-cycle pulse in the final stop-bit cycle
module fifo_uart_tx #(
    parameter int unsigned pClkDiv   = 104,
    parameter int unsigned pStopBits = 1
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iEn,
    input  logic       iFifoEmpty,
    input  logic [7:0] iFifoData,
    output logic       oFifoRdEn,
    output logic       oTx,
    output logic       oBusy,
    output logic       oByteDone
);

    localparam int unsigned    CW          = $clog2(pClkDiv);
    localparam logic [CW-1:0]  BAUD_RELOAD = CW'(pClkDiv - 1);
    localparam logic [2:0]     LAST_STOP   = 3'(pStopBits - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] baud_reg,  baud_next;
    logic [2:0]    bit_reg,   bit_next;     // data bit index, reused as stop-bit index
    logic [7:0]    shift_reg, shift_next;
    logic          tx_reg,    tx_next;
    logic          rd_en_reg, rd_en_next;
    logic          busy_reg,  busy_next;
    logic          done_reg,  done_next;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_reg <= S_IDLE;
            baud_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
            rd_en_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
            rd_en_reg <= rd_en_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    // The line level for the next cycle is computed on the transition into
    // each bit, so oTx is a flop that only changes on bit boundaries.
    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        tx_next    = tx_reg;

        unique case (state_reg)
            S_IDLE: begin
                tx_next = 1'b1;
                if (iEn && !iFifoEmpty) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                state_next = S_LOAD;
            end
            S_LOAD: begin
                shift_next = iFifoData;
                baud_next  = BAUD_RELOAD;
                tx_next    = 1'b0;
                state_next = S_START;
            end
            S_START: begin
                if (baud_reg == '0) begin
                    baud_next  = BAUD_RELOAD;
                    bit_next   = '0;
                    tx_next    = shift_reg[0];
                    shift_next = {1'b0, shift_reg[7:1]};
                    state_next = S_DATA;
                end else begin
                    baud_next = baud_reg - 1'b1;
                end
            end
            S_DATA: begin
                if (baud_reg == '0) begin
                    baud_next = BAUD_RELOAD;
                    if (bit_reg == 3'd7) begin
                        bit_next   = '0;
                        tx_next    = 1'b1;
                        state_next = S_STOP;
                    end else begin
                        bit_next   = bit_reg + 3'd1;
                        tx_next    = shift_reg[0];
                        shift_next = {1'b0, shift_reg[7:1]};
                    end
                end else begin
                    baud_next = baud_reg - 1'b1;
                end
            end
            S_STOP: begin
                if (baud_reg == '0) begin
                    if (bit_reg == LAST_STOP) begin
                        bit_next   = '0;
                        state_next = S_IDLE;
                    end else begin
                        bit_next  = bit_reg + 3'd1;
                        baud_next = BAUD_RELOAD;
                    end
                end else begin
                    baud_next = baud_reg - 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Registered strobes are decoded from the upcoming state so they line up
    // with the cycle in which that state is current.
    always_comb begin
        rd_en_next = (state_next == S_FETCH);
        busy_next  = (state_next != S_IDLE);
        done_next  = (state_next == S_STOP) && (baud_next == '0) &&
                     (bit_next == LAST_STOP);
    end

    assign oFifoRdEn = rd_en_reg;
    assign oTx       = tx_reg;
    assign oBusy     = busy_reg;
    assign oByteDone = done_reg;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx
// Two transmitters (1 and 2 stop bits, 4 clocks per bit), each fed by a
// small 8-deep FIFO model with registered read data.
module tb_fifo_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       fclr;
    logic [1:0] en;
    logic [1:0] wr_en;
    logic [7:0] wr_data [2];
    logic [7:0] fmem [2][8];
    logic [2:0] wp [2];
    logic [2:0] rp [2];
    logic [3:0] fcount [2];
    logic [7:0] rdata [2];
    logic [1:0] empty_v;
    logic [1:0] rd_en_v;
    logic       tx0, busy0, done0;
    logic       tx1, busy1, done1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rd_cnt   = 0;
    int bad_rd   = 0;
    int start_cyc = 0;
    int last_gap  = 0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // transmitted bits, index 0 first: start, d0..d7, stop
    } vec_t;
    vec_t vecs [5];

    always #5 clk = ~clk;

    fifo_uart_tx #(.pClkDiv(4), .pStopBits(1)) dut0 (
        .iClk(clk), .iRst(rst), .iEn(en[0]), .iFifoEmpty(empty_v[0]),
        .iFifoData(rdata[0]), .oFifoRdEn(rd_en_v[0]), .oTx(tx0),
        .oBusy(busy0), .oByteDone(done0)
    );

    fifo_uart_tx #(.pClkDiv(4), .pStopBits(2)) dut1 (
        .iClk(clk), .iRst(rst), .iEn(en[1]), .iFifoEmpty(empty_v[1]),
        .iFifoData(rdata[1]), .oFifoRdEn(rd_en_v[1]), .oTx(tx1),
        .oBusy(busy1), .oByteDone(done1)
    );

    assign empty_v[0] = (fcount[0] == 4'd0);
    assign empty_v[1] = (fcount[1] == 4'd0);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (fclr) begin
                wp[i]     <= '0;
                rp[i]     <= '0;
                fcount[i] <= '0;
                rdata[i]  <= '0;
            end else begin
                if (wr_en[i] && fcount[i] != 4'd8) begin
                    fmem[i][wp[i]] <= wr_data[i];
                    wp[i]          <= wp[i] + 3'd1;
                end
                if (rd_en_v[i] && fcount[i] != 4'd0) begin
                    rdata[i] <= fmem[i][rp[i]];
                    rp[i]    <= rp[i] + 3'd1;
                end
                fcount[i] <= fcount[i]
                           + ((wr_en[i] && fcount[i] != 4'd8) ? 4'd1 : 4'd0)
                           - ((rd_en_v[i] && fcount[i] != 4'd0) ? 4'd1 : 4'd0);
            end
        end
        if (rd_en_v[0]) rd_cnt <= rd_cnt + 1;
    end

    always @(negedge clk) begin
        if (!rst && !fclr && rd_en_v[0] && fcount[0] == 4'd0) bad_rd <= bad_rd + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push(input int i, input logic [7:0] b);
        @(negedge clk);
        wr_en[i]   = 1'b1;
        wr_data[i] = b;
        @(negedge clk);
        wr_en[i]   = 1'b0;
    endtask

    // Waits for the start bit on dut0, then samples 40 cycles of line and
    // byte-done. drop_at >= 0 drops en[0] at that sample index.
    task automatic capture(input logic [9:0] frame, input int drop_at, output logic [7:0] dec);
        logic [39:0] wave, dwave, exp_wave;
        int k;
        k = 0;
        @(negedge clk);
        while (tx0 !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("start_bit_seen", 64'(k < 200), 64'd1);
        last_gap  = cyc - start_cyc;
        start_cyc = cyc;
        for (int s = 0; s < 40; s++) begin
            if (s > 0) @(negedge clk);
            if (s == drop_at) en[0] = 1'b0;
            wave[s]     = tx0;
            dwave[s]    = done0;
            exp_wave[s] = frame[s / 4];
        end
        check("tx_waveform", 64'(wave), 64'(exp_wave));
        check("byte_done_pulse", 64'(dwave), 64'h80_0000_0000);
        for (int b = 0; b < 8; b++) dec[b] = wave[6 + 4 * b];
        $display("frame: start cycle %0d, decoded %02h, required %02h", start_cyc, dec, frame[8:1]);
    endtask

    initial begin
        logic [7:0] dec;
        int rd0;
        int k;
        logic [43:0] w2, d2;

        vecs[0] = '{8'hA5, 10'b1_10100101_0};
        vecs[1] = '{8'h00, 10'b1_00000000_0};
        vecs[2] = '{8'hFF, 10'b1_11111111_0};
        vecs[3] = '{8'h3C, 10'b1_00111100_0};
        vecs[4] = '{8'h81, 10'b1_10000001_0};

        // Reset, with enable high and the FIFO empty
        rst = 1'b1; fclr = 1'b1; en = 2'b11; wr_en = 2'b00;
        wr_data[0] = '0; wr_data[1] = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_tx", 64'(tx0), 64'd1);
        check("reset_busy", 64'(busy0), 64'd0);
        check("reset_rd_en", 64'(rd_en_v[0]), 64'd0);
        check("reset_done", 64'(done0), 64'd0);
        rst = 1'b0; fclr = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_tx", 64'(tx0), 64'd1);
        check("idle_busy", 64'(busy0), 64'd0);
        check("idle_no_read", 64'(rd_cnt), 64'd0);

        // Single-byte frames from the vector table
        for (int v = 0; v < 5; v++) begin
            rd0 = rd_cnt;
            push(0, vecs[v].data);
            capture(vecs[v].frame, -1, dec);
            check("vec_decode", 64'(dec), 64'(vecs[v].data));
            check("vec_one_read", 64'(rd_cnt - rd0), 64'd1);
        end
        repeat (4) @(negedge clk);
        check("vec_idle_busy", 64'(busy0), 64'd0);

        // Burst of eight bytes from a full FIFO, 43-cycle frame period
        en[0] = 1'b0;
        for (int b = 1; b <= 8; b++) push(0, 8'(b));
        check("burst_fifo_full", 64'(fcount[0]), 64'd8);
        rd0 = rd_cnt;
        en[0] = 1'b1;
        for (int b = 1; b <= 8; b++) begin
            capture({1'b1, 8'(b), 1'b0}, -1, dec);
            check("burst_order", 64'(dec), 64'(b));
            if (b > 1) check("burst_period", 64'(last_gap), 64'd43);
        end
        repeat (20) @(negedge clk);
        check("burst_fifo_empty", 64'(fcount[0]), 64'd0);
        check("burst_reads", 64'(rd_cnt - rd0), 64'd8);
        check("burst_idle_busy", 64'(busy0), 64'd0);

        // Enable dropped during the second frame's data bits
        en[0] = 1'b0;
        push(0, 8'h11); push(0, 8'h22); push(0, 8'h33);
        rd0 = rd_cnt;
        en[0] = 1'b1;
        capture(10'b1_00010001_0, -1, dec);
        capture(10'b1_00100010_0, 12, dec);
        check("gate_frame2", 64'(dec), 64'h22);
        repeat (20) @(negedge clk);
        check("gate_busy", 64'(busy0), 64'd0);
        check("gate_fifo_left", 64'(fcount[0]), 64'd1);
        check("gate_reads", 64'(rd_cnt - rd0), 64'd2);
        en[0] = 1'b1;
        capture(10'b1_00110011_0, -1, dec);
        check("gate_frame3", 64'(dec), 64'h33);

        // Reset during data bit 3 of 0xA5 (bit 3 is 0), then 0xC3 follows intact
        en[0] = 1'b0;
        push(0, 8'hA5); push(0, 8'hC3);
        rd0 = rd_cnt;
        en[0] = 1'b1;
        k = 0;
        @(negedge clk);
        while (tx0 !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("abort_start_seen", 64'(k < 200), 64'd1);
        repeat (17) @(negedge clk);
        check("abort_bit3_low", 64'(tx0), 64'd0);
        check("abort_busy_before", 64'(busy0), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_tx_high", 64'(tx0), 64'd1);
        check("abort_busy_low", 64'(busy0), 64'd0);
        rst = 1'b0;
        capture(10'b1_11000011_0, -1, dec);
        check("abort_next_byte", 64'(dec), 64'hC3);
        check("abort_reads", 64'(rd_cnt - rd0), 64'd2);
        check("abort_fifo_empty", 64'(fcount[0]), 64'd0);

        // Two stop bits, byte 0x00: 36 cycles low, 8 high, done in the last
        push(1, 8'h00);
        k = 0;
        @(negedge clk);
        while (tx1 !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("stop2_start_seen", 64'(k < 200), 64'd1);
        for (int s = 0; s < 44; s++) begin
            if (s > 0) @(negedge clk);
            w2[s] = tx1;
            d2[s] = done1;
        end
        check("stop2_waveform", 64'(w2), 64'hFF000000000);
        check("stop2_done", 64'(d2), 64'h80000000000);
        @(negedge clk);
        @(negedge clk);
        check("stop2_idle_busy", 64'(busy1), 64'd0);
        $display("stop2 frame: line %011h, done %011h", w2, d2);

        check("no_underflow_read", 64'(bad_rd), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1);
    end

endmodule
